axis_wrr_arbiter: RTL and testbench
===================================

# axis_wrr_arbiter

Weighted round-robin, packet-atomic arbiter that drives the select inputs of the AXI4-S multiplexer in the AFU datapath. It is a drop-in replacement for the mux's fair arbiter. It keeps a grant locked for a whole packet, grants each channel up to a configurable number of consecutive packets, then rotates. It never grants a channel whose weight is zero.

## Interface
- NUM_CH, 4, number of requesting channels (1-8)
- WEIGHT_W, 4, width of each per-channel weight
- SEL_W, $clog2(NUM_CH) (min 1), width of out_select
- clk  in  1  clock; the block has one clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  NUM_CH  per-channel head-beat valid (the mux's registered tvalid)
- in_last  in  NUM_CH  per-channel head-beat tlast
- out_ready  in  1  mux output stage can take a beat (~tvalid | tready downstream)
- cfg_weight  in  NUM_CH*WEIGHT_W  packets per turn; channel i uses bits [i*WEIGHT_W +: WEIGHT_W]; 0 = masked
- out_select  out  SEL_W  granted channel index
- out_select_1hot  out  NUM_CH  one-hot of out_select; all zero when no grant
- out_valid  out  1  granted channel presents a valid beat this cycle
- out_pkt_done  out  1  pulse: last beat of the granted packet accepted this cycle

## Operation
- State registers:
  - gnt_act: grant held.
  - cur: granted index, SEL_W bits.
  - credit: WEIGHT_W bits.
  - last_srv: index last served, the round-robin pointer.
- eligible[i] = in_valid[i] & (cfg_weight[i] != 0).
- Outputs are combinational from the registers and inputs:
  - out_select = cur.
  - out_select_1hot = gnt_act ? (1 << cur) : 0.
  - out_valid = gnt_act & in_valid[cur].
- Beat accept: acc = out_valid & out_ready.
- Packet done: done = acc & in_last[cur]. out_pkt_done = done.
- FSM has two states, IDLE (gnt_act=0) and GRANT (gnt_act=1).
- IDLE:
  - If any eligible, pick p = the first eligible index strictly after last_srv, wrapping.
  - Load cur=p, credit=cfg_weight[p], and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, no done: hold cur and credit. This applies even if in_valid[cur] drops mid-packet, because a grant is never revoked before tlast.
- GRANT, done and credit > 1 and eligible[cur]:
  - Keep cur and set credit = credit-1.
  - The next packet follows with no bubble.
- GRANT, done otherwise:
  - Set last_srv = cur.
  - Pick p from eligible with the current-cycle value, starting after cur and masking cur if another channel is eligible.
  - If p exists: cur=p, credit=cfg_weight[p], and stay in GRANT.
  - Else go to IDLE.
  - If only cur is eligible, it is re-granted with fresh credit.
- cfg_weight is sampled only when a grant is loaded. A change mid-turn takes effect at the next load.
- Weight set to 0 while granted: the current packet completes, then the channel is never picked again.
- credit never underflows, because a load of 0 is impossible (masked channels cannot be picked).
- Reset (async assert):
  - gnt_act=0, cur=0, credit=0, last_srv=NUM_CH-1, so channel 0 wins first.
  - Outputs at reset: out_select=0, out_select_1hot=0, out_valid=0, out_pkt_done=0.
  - Reset mid-packet drops the grant immediately; the mux is reset on the same rst_n.
  - Deassertion is synchronized externally.

## Timing
- Arbitration latency from IDLE: eligible in cycle N gives a grant and out_valid in cycle N+1.
- Packet-to-packet handoff: zero bubbles. The new cur is selected in the cycle after done.
- A single-beat packet with in_last=1 yields done on its first accepted cycle.
- out_ready=0 stalls: no state change, and the grant is held.
- The critical path is eligible -> rotate-priority pick -> cur D input, evaluated in a single cycle.

## Structure
- Shared package axis_arb_pkg:
  - MAX_CH=8.
  - Default WEIGHT_W.
  - typedef enum {ARB_IDLE, ARB_GRANT} arb_state_e.
  - Function onehot_to_idx.
- Sub-module axis_rr_pick: combinational rotating-priority picker.
  - Inputs: req[NUM_CH], ptr[SEL_W].
  - Outputs: pick index, pick_valid.
  - Uses the double-width mask technique.
- The top level holds the FSM, credit counter and output decode.

## Test plan
- Reset, then in_valid=4'b1111, all weights 1, 1-beat packets, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles starting 1 cycle after valid; out_pkt_done high every cycle.
- Weights {1,3,0,2} for ch0..ch3, all valid, 1-beat packets -> repeating grant sequence 0,1,1,1,3,3; channel 2 is never selected.
- Ch1 sends a 4-beat packet, out_ready toggling 1,0,1,0..., ch0 is valid throughout -> sel stays 1 until the 4th accepted beat; out_pkt_done is a single pulse; ch0 is granted the next cycle.
- Only ch2 valid, weight 2, continuous 2-beat packets -> ch2 is re-granted indefinitely with no idle cycle; out_valid stays high.
- in_valid[cur] drops mid-packet for 3 cycles -> the grant is held, out_valid=0 for those cycles, and the packet resumes without switching.
- rst_n asserted mid-packet on ch3 -> out_select_1hot=0 and out_valid=0 immediately (async); after release, the first grant goes to the lowest eligible index.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI4-S weighted round-robin arbiter.
package axis_arb_pkg;

    localparam int MAX_CH       = 8;
    localparam int DEF_WEIGHT_W = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    // Bitwise OR of set positions; exact for a one-hot (or all-zero) input.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational rotating-priority picker: first requester strictly after ptr, wrapping.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  pick,
    output logic              pick_valid
);

    localparam int DW = 2 * NUM_CH;

    logic [DW-1:0]     w_dbl;
    logic [DW-1:0]     w_keep;
    logic [DW-1:0]     w_masked;
    logic [DW-1:0]     w_low;
    logic [MAX_CH-1:0] w_oh;

    // Doubling the request vector turns the wrap-around search into a plain
    // lowest-set-bit search above ptr; the upper copy folds back onto the lower.
    always_comb begin
        w_dbl  = {req, req};
        w_keep = '0;
        for (int j = 0; j < DW; j++) begin
            w_keep[j] = (j > int'(ptr));
        end
        w_masked = w_dbl & w_keep;
        w_low    = w_masked & (~w_masked + {{(DW-1){1'b0}}, 1'b1});
        w_oh     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_oh[i] = w_low[i] | w_low[i+NUM_CH];
        end
        pick       = SEL_W'(onehot_to_idx(w_oh));
        pick_valid = |req;
    end

endmodule

// File: rtl/axis_wrr_arbiter.sv
// Packet-atomic weighted round-robin arbiter driving the AXI4-S mux select lines.
module axis_wrr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH-1:0]            in_last,
    input  logic                         out_ready,
    input  logic [NUM_CH*WEIGHT_W-1:0]   cfg_weight,
    output logic [SEL_W-1:0]             out_select,
    output logic [NUM_CH-1:0]            out_select_1hot,
    output logic                         out_valid,
    output logic                         out_pkt_done
);

    arb_state_e          r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_cur, w_cur_nxt;
    logic [WEIGHT_W-1:0] r_credit, w_credit_nxt;
    logic [SEL_W-1:0]    r_last_srv, w_last_nxt;

    logic [NUM_CH-1:0]   w_elig;
    logic [NUM_CH-1:0]   w_cur_oh;
    logic [NUM_CH-1:0]   w_others;
    logic [NUM_CH-1:0]   w_req;
    logic [SEL_W-1:0]    w_ptr;
    logic [SEL_W-1:0]    w_pick;
    logic                w_pick_valid;
    logic [WEIGHT_W-1:0] w_pick_weight;
    logic                w_gnt;
    logic                w_done;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_elig[i]   = in_valid[i] & (|cfg_weight[i*WEIGHT_W +: WEIGHT_W]);
        assign w_cur_oh[i] = (r_cur == SEL_W'(i));
    end

    assign w_gnt           = (r_state == ARB_GRANT);
    assign out_select      = r_cur;
    assign out_select_1hot = w_gnt ? w_cur_oh : '0;
    assign out_valid       = w_gnt & in_valid[r_cur];
    assign w_done          = out_valid & out_ready & in_last[r_cur];
    assign out_pkt_done    = w_done;

    // On handoff the current channel only competes when nobody else is eligible.
    assign w_others      = w_elig & ~w_cur_oh;
    assign w_req         = (w_gnt && (|w_others)) ? w_others : w_elig;
    assign w_ptr         = w_gnt ? r_cur : r_last_srv;
    assign w_pick_weight = cfg_weight[w_pick*WEIGHT_W +: WEIGHT_W];

    axis_rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req        (w_req),
        .ptr        (w_ptr),
        .pick       (w_pick),
        .pick_valid (w_pick_valid)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_credit_nxt = r_credit;
        w_last_nxt   = r_last_srv;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt  = ARB_GRANT;
                    w_cur_nxt    = w_pick;
                    w_credit_nxt = w_pick_weight;
                end
            end
            ARB_GRANT: begin
                if (w_done) begin
                    if ((r_credit > WEIGHT_W'(1)) && w_elig[r_cur]) begin
                        w_credit_nxt = r_credit - WEIGHT_W'(1);
                    end else begin
                        w_last_nxt = r_cur;
                        if (w_pick_valid) begin
                            w_cur_nxt    = w_pick;
                            w_credit_nxt = w_pick_weight;
                        end else begin
                            w_state_nxt = ARB_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_cur      <= '0;
            r_credit   <= '0;
            r_last_srv <= SEL_W'(NUM_CH - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_credit   <= w_credit_nxt;
            r_last_srv <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// Scenario bench for axis_wrr_arbiter: expected grants queued at stimulus, popped on packet done.
module tb_axis_wrr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic        out_ready;
    logic [15:0] cfg_weight;
    logic [1:0]  out_select;
    logic [3:0]  out_select_1hot;
    logic        out_valid;
    logic        out_pkt_done;

    int errors = 0;
    int checks = 0;
    int sb_q[$];

    axis_wrr_arbiter #(.NUM_CH(4), .WEIGHT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_last         (in_last),
        .out_ready       (out_ready),
        .cfg_weight      (cfg_weight),
        .out_select      (out_select),
        .out_select_1hot (out_select_1hot),
        .out_valid       (out_valid),
        .out_pkt_done    (out_pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0; in_last = '0; out_ready = 1'b1; cfg_weight = 16'h1111;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1; cfg_weight = 16'h1111;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_select !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", out_select); end
        checks++; if (out_select_1hot !== 4'b0) begin errors++; $display("FAIL reset_1hot: got %b want 0000", out_select_1hot); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", out_pkt_done); end
        @(negedge clk); rst_n = 1'b1; #1;
        @(negedge clk); #1;
        checks++; if (out_select !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_first_grant: got sel=%0d valid=%b want sel=0 valid=1", out_select, out_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        do_reset();
        cfg_weight = 16'h1111; in_last = 4'hF; out_ready = 1'b1;
        @(negedge clk); in_valid = 4'hF; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_latency: got valid=%b want 0", out_valid); end
        sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2); sb_q.push_back(3); sb_q.push_back(0);
        repeat (5) begin
            @(negedge clk); #1;
            checks++; if (out_pkt_done !== 1'b1) begin errors++; $display("FAIL rr_done: got %b want 1", out_pkt_done); end
            if (out_pkt_done === 1'b1 && sb_q.size() > 0) begin
                logic [3:0] oh;
                exp = sb_q.pop_front();
                oh = 4'b0001 << exp;
                checks++; if (out_select !== 2'(exp)) begin errors++; $display("FAIL rr_sel: got %0d want %0d", out_select, exp); end
                checks++; if (out_select_1hot !== oh) begin errors++; $display("FAIL rr_1hot: got %b want %b", out_select_1hot, oh); end
            end
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rr_missing: got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_weights();
        int exp;
        int pat[6] = '{0, 1, 1, 1, 3, 3};
        do_reset();
        cfg_weight = {4'd2, 4'd0, 4'd3, 4'd1}; in_last = 4'hF; out_ready = 1'b1;
        @(negedge clk); in_valid = 4'hF;
        for (int r = 0; r < 2; r++) for (int k = 0; k < 6; k++) sb_q.push_back(pat[k]);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (out_pkt_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++; $display("FAIL wrr_extra: got sel=%0d want no grant", out_select);
                end else begin
                    exp = sb_q.pop_front();
                    checks++; if (out_select !== 2'(exp)) begin errors++; $display("FAIL wrr_sel: got %0d want %0d", out_select, exp); end
                end
            end else begin
                checks++; errors++; $display("FAIL wrr_done: got 0 want 1");
            end
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL wrr_missing: got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_stall();
        int  beats = 0;
        int  exp;
        int  dones = 0;
        logic rdy = 1'b1;
        logic exp_done;
        do_reset();
        cfg_weight = 16'h1111; in_last = 4'b0001; out_ready = 1'b1;
        @(negedge clk); in_valid = 4'b0010;
        sb_q.push_back(1);
        for (int c = 0; c < 20 && beats < 4; c++) begin
            @(negedge clk);
            in_valid = 4'b0011; out_ready = rdy; in_last = {2'b00, (beats == 3), 1'b1};
            #1;
            checks++; if (out_select !== 2'd1 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold: got sel=%0d valid=%b want sel=1 valid=1", out_select, out_valid);
            end
            exp_done = rdy && (beats == 3);
            checks++; if (out_pkt_done !== exp_done) begin errors++; $display("FAIL stall_done: got %b want %b", out_pkt_done, exp_done); end
            if (out_pkt_done === 1'b1) begin
                dones++;
                if (sb_q.size() > 0) begin
                    exp = sb_q.pop_front();
                    checks++; if (out_select !== 2'(exp)) begin errors++; $display("FAIL stall_sel: got %0d want %0d", out_select, exp); end
                end
            end
            if (rdy) beats++;
            rdy = ~rdy;
        end
        checks++; if (beats != 4 || dones != 1) begin errors++; $display("FAIL stall_beats: got beats=%0d dones=%0d want 4 and 1", beats, dones); end
        @(negedge clk); out_ready = 1'b1; #1;
        checks++; if (out_select !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_next: got sel=%0d valid=%b want sel=0 valid=1", out_select, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic ph = 1'b0;
        int exp;
        do_reset();
        cfg_weight = 16'h0200; out_ready = 1'b1;
        @(negedge clk); in_valid = 4'b0100; in_last = 4'b0000;
        repeat (6) sb_q.push_back(2);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); in_last = {1'b0, ph, 2'b00}; #1;
            checks++; if (out_valid !== 1'b1 || out_select !== 2'd2) begin
                errors++; $display("FAIL b2b_valid: got sel=%0d valid=%b want sel=2 valid=1", out_select, out_valid);
            end
            checks++; if (out_pkt_done !== ph) begin errors++; $display("FAIL b2b_done: got %b want %b", out_pkt_done, ph); end
            if (out_pkt_done === 1'b1 && sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                checks++; if (out_select !== 2'(exp)) begin errors++; $display("FAIL b2b_sel: got %0d want %0d", out_select, exp); end
            end
            ph = ~ph;
        end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_valid_drop();
        int exp;
        do_reset();
        cfg_weight = 16'h1111; out_ready = 1'b1;
        @(negedge clk); in_valid = 4'b1000; in_last = 4'b0000;
        @(negedge clk); #1;
        checks++; if (out_select !== 2'd3 || out_valid !== 1'b1 || out_pkt_done !== 1'b0) begin
            errors++; $display("FAIL drop_first: got sel=%0d valid=%b done=%b want 3 1 0", out_select, out_valid, out_pkt_done);
        end
        repeat (3) begin
            @(negedge clk); in_valid = 4'b0001; #1;
            checks++; if (out_select_1hot !== 4'b1000 || out_valid !== 1'b0 || out_pkt_done !== 1'b0) begin
                errors++; $display("FAIL drop_hold: got 1hot=%b valid=%b done=%b want 1000 0 0", out_select_1hot, out_valid, out_pkt_done);
            end
        end
        @(negedge clk); in_valid = 4'b1001; in_last = 4'b1000; sb_q.push_back(3); #1;
        checks++; if (out_pkt_done !== 1'b1) begin errors++; $display("FAIL drop_done: got %b want 1", out_pkt_done); end
        if (out_pkt_done === 1'b1 && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            checks++; if (out_select !== 2'(exp)) begin errors++; $display("FAIL drop_sel: got %0d want %0d", out_select, exp); end
        end
        @(negedge clk); in_valid = 4'b0001; in_last = 4'b0001; #1;
        checks++; if (out_select !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL drop_next: got sel=%0d valid=%b want sel=0 valid=1", out_select, out_valid);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        cfg_weight = 16'h1111; out_ready = 1'b1;
        @(negedge clk); in_valid = 4'b1000; in_last = 4'b0000;
        @(negedge clk); #1;
        checks++; if (out_select !== 2'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_grant: got sel=%0d valid=%b want sel=3 valid=1", out_select, out_valid);
        end
        #1; in_valid = 4'b1110; rst_n = 1'b0; #1;
        checks++; if (out_select_1hot !== 4'b0 || out_valid !== 1'b0 || out_pkt_done !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got 1hot=%b valid=%b done=%b want 0000 0 0", out_select_1hot, out_valid, out_pkt_done);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got valid=%b want 0", out_valid); end
        @(negedge clk); #1;
        checks++; if (out_select !== 2'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_regrant: got sel=%0d valid=%b want sel=1 valid=1", out_select, out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b0; cfg_weight = '0;
        test_reset();
        test_round_robin();
        test_weights();
        test_stall();
        test_back_to_back();
        test_valid_drop();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
